trace_fifo_arbiter: RTL and testbench

- Shares one trace FIFO write port among num_src_p backpressure/sampler front-ends.
- Each front-end presents a {flag, payload} packet, where flag=1 marks a lost-sample count packet.
- Flag packets are granted ahead of sample packets. Within a class, sources are served round-robin. The winner's packet goes to a registered output stage tagged with its source id.

---
 rtl/trace_pkg.sv | 22 ++
 rtl/trace_rr_pick.sv | 38 +++
 rtl/trace_fifo_arbiter.sv | 87 ++++++++
 tb/tb_trace_fifo_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace path: packet layout, id sizing
// and flag extraction, also used by the backpressure front-end.
package trace_pkg;

    localparam int SAMPLE_W_DEFAULT = 16;
    localparam int PKT_W_MAX        = 64;

    typedef struct packed {
        logic                        flag;
        logic [SAMPLE_W_DEFAULT-1:0] payload;
    } trace_pkt_t;

    function automatic int id_width(input int num_src);
        return (num_src > 2) ? $clog2(num_src) : 1;
    endfunction

    // The flag sits directly above the payload, so only that bit is read.
    function automatic logic flag_of(input logic [PKT_W_MAX-1:0] pkt, input int sample_w);
        return pkt[sample_w];
    endfunction

endpackage

// File: rtl/trace_rr_pick.sv
// Round-robin picker: first set candidate at or after i_ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module trace_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_cand,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_masked;
    logic           w_found;

    always_comb begin
        w_dbl    = {i_cand, i_cand};
        w_masked = '0;
        // Lower copy masked below the pointer; upper copy supplies the wrap.
        for (int j = 0; j < 2*N; j++) begin
            w_masked[j] = w_dbl[j] & ((j >= N) || (j >= int'(i_ptr)));
        end
        w_found = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int j = 0; j < 2*N; j++) begin
            if (!w_found && w_masked[j]) begin
                w_found = 1'b1;
                o_idx   = (j >= N) ? ID_W'(j - N) : ID_W'(j);
                o_grant[(j >= N) ? (j - N) : j] = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/trace_fifo_arbiter.sv
// Arbitrates N trace sources onto one FIFO write port: flag packets first,
// round-robin within a class, one registered output stage tagged with source id.
module trace_fifo_arbiter
    import trace_pkg::*;
#(
    parameter  int num_src_p      = 4,
    parameter  int sample_width_p = 16,
    localparam int id_width_lp    = id_width(num_src_p),
    localparam int pkt_w_lp       = sample_width_p + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [num_src_p-1:0]            src_en,
    input  logic [num_src_p*pkt_w_lp-1:0]   src_data,
    input  logic [num_src_p-1:0]            src_valid,
    output logic [num_src_p-1:0]            src_ready,
    output logic [id_width_lp+pkt_w_lp-1:0] fifo_data,
    output logic                            fifo_valid,
    input  logic                            fifo_ready
);

    logic [num_src_p-1:0]            w_elig;
    logic [num_src_p-1:0]            w_flag_elig;
    logic [num_src_p-1:0]            w_cand;
    logic [num_src_p-1:0]            w_grant;
    logic [id_width_lp-1:0]          w_idx;
    logic                            w_any;
    logic                            w_load;
    logic [pkt_w_lp-1:0]             w_win_pkt;
    logic [id_width_lp-1:0]          r_rr_ptr;
    logic                            r_fifo_valid;
    logic [id_width_lp+pkt_w_lp-1:0] r_fifo_data;

    always_comb begin
        w_elig      = src_valid & src_en;
        w_flag_elig = '0;
        for (int i = 0; i < num_src_p; i++) begin
            w_flag_elig[i] = w_elig[i] &
                flag_of(PKT_W_MAX'(src_data[i*pkt_w_lp +: pkt_w_lp]), sample_width_p);
        end
        w_cand = (|w_flag_elig) ? w_flag_elig : w_elig;
    end

    trace_rr_pick #(
        .N    (num_src_p),
        .ID_W (id_width_lp)
    ) u_pick (
        .i_cand  (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_load    = ~r_fifo_valid | fifo_ready;
    assign src_ready = (w_load & ~rst) ? w_grant : '0;

    // Payload mux keyed off the one-hot grant, keeping payload out of the ready path.
    always_comb begin
        w_win_pkt = '0;
        for (int i = 0; i < num_src_p; i++) begin
            if (w_grant[i]) begin
                w_win_pkt = src_data[i*pkt_w_lp +: pkt_w_lp];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_valid <= 1'b0;
            r_fifo_data  <= '0;
            r_rr_ptr     <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_fifo_valid <= 1'b1;
                r_fifo_data  <= {w_idx, w_win_pkt};
                r_rr_ptr     <= (w_idx == id_width_lp'(num_src_p - 1)) ? '0 : w_idx + 1'b1;
            end else begin
                r_fifo_valid <= 1'b0;
            end
        end
    end

    assign fifo_data  = r_fifo_data;
    assign fifo_valid = r_fifo_valid;

endmodule

// File: tb/tb_trace_fifo_arbiter.sv
// Bench for trace_fifo_arbiter: reference arbitration model feeding a
// scoreboard, plus directed checks on a 4-source and a 3-source instance.
module tb_trace_fifo_arbiter;

    localparam int N  = 4;
    localparam int SW = 16;
    localparam int PW = SW + 1;
    localparam int DW = 2 + PW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    en, valid, ready;
    logic [N*PW-1:0] data;
    logic            fifo_ready;
    logic [DW-1:0]   fdata;
    logic            fvalid;

    logic [2:0]      en3, valid3, ready3;
    logic [3*PW-1:0] data3;
    logic            rdy3;
    logic [DW-1:0]   fdata3;
    logic            fvalid3;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] sb3[$];
    logic          m_valid;
    int            m_ptr;

    always #5 clk = ~clk;

    trace_fifo_arbiter #(.num_src_p(4), .sample_width_p(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_en     (en),
        .src_data   (data),
        .src_valid  (valid),
        .src_ready  (ready),
        .fifo_data  (fdata),
        .fifo_valid (fvalid),
        .fifo_ready (fifo_ready)
    );

    trace_fifo_arbiter #(.num_src_p(3), .sample_width_p(16)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .src_en     (en3),
        .src_data   (data3),
        .src_valid  (valid3),
        .src_ready  (ready3),
        .fifo_data  (fdata3),
        .fifo_valid (fvalid3),
        .fifo_ready (rdy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: evaluated mid-cycle, advances state as of the next edge.
    always @(negedge clk) begin : model
        logic [N-1:0] elig, fl, cand;
        logic [31:0]  exp_rdy;
        int           win, idx;
        logic         load;
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            sb.delete();
            check("rst_src_ready", ready, 0);
        end else begin
            check("fifo_valid", fvalid, m_valid);
            if (m_valid) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    check("fifo_data", fdata, sb[0]);
                    if (fifo_ready) void'(sb.pop_front());
                end
            end
            elig = valid & en;
            fl   = '0;
            for (int i = 0; i < N; i++) fl[i] = elig[i] & data[i*PW + SW];
            cand = (|fl) ? fl : elig;
            win  = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && cand[idx]) win = idx;
            end
            load    = !m_valid || fifo_ready;
            exp_rdy = (load && win >= 0) ? (32'd1 << win) : 32'd0;
            check("src_ready", ready, exp_rdy);
            if (load) begin
                if (win >= 0) begin
                    sb.push_back({2'(win), data[win*PW +: PW]});
                    m_valid = 1'b1;
                    m_ptr   = (win + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        int seq_a[6];
        int seq_b[4];
        seq_a = '{3, 0, 1, 3, 0, 1};
        seq_b = '{3, 0, 3, 0};
        rst = 1'b1; en = '0; valid = '0; data = '0; fifo_ready = 1'b0;
        en3 = 3'b111; valid3 = '0; data3 = '0; rdy3 = 1'b1;
        for (int i = 0; i < N; i++) data[i*PW +: PW] = {1'b0, 16'hA000 + 16'(i)};
        for (int i = 0; i < 3; i++) data3[i*PW +: PW] = {1'b0, 16'hB000 + 16'(i)};
        repeat (2) @(posedge clk);
        #1;
        check("rst_fifo_valid", fvalid, 0);
        check("rst_fifo_data", fdata, 0);
        check("rst_ready", ready, 0);
        rst = 1'b0;

        // all four valid, unflagged
        en = 4'b1111; valid = 4'b1111; fifo_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", ready, 32'd1 << (k % 4));
            if (k > 0) begin
                check("rr_valid", fvalid, 1);
                check("rr_id", fdata[DW-1 -: 2], (k - 1) % 4);
            end
            step();
        end
        valid = 4'b1000;
        #1; check("align_grant", ready, 4'b1000);
        step();
        valid = '0;
        step();

        // flagged source 3 jumps the queue
        valid = 4'b1101;
        data[3*PW +: PW] = {1'b1, 16'h0005};
        #1; check("flag_first", ready, 4'b1000);
        step();
        valid[3] = 1'b0;
        #1;
        check("flag_out", fdata, {2'd3, 1'b1, 16'h0005});
        check("after_flag", ready, 4'b0001);
        step();
        valid = '0;
        data[3*PW +: PW] = {1'b0, 16'hA003};
        step();
        step();

        // backpressure holds source 1's packet
        valid = 4'b1111; fifo_ready = 1'b0;
        #1; check("hold_load", ready, 4'b0010);
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_ready", ready, 0);
            check("hold_valid", fvalid, 1);
            check("hold_data", fdata, {2'd1, 1'b0, 16'hA001});
            step();
        end
        fifo_ready = 1'b1;
        #1; check("resume_grant", ready, 4'b0100);
        step();

        // disabled sources are skipped
        en = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("en_mask", ready & 4'b0100, 0);
            check("en_rot", ready, 32'd1 << seq_a[k]);
            step();
        end
        en = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("en_rot2", ready, 32'd1 << seq_b[k]);
            step();
        end
        en = 4'b1111; valid = '0;
        step();
        step();

        // asynchronous reset while a packet is buffered
        valid = 4'b1111;
        step();
        valid = '0;
        #2;
        check("pre_arst_valid", fvalid, 1);
        rst = 1'b1;
        #1;
        check("arst_valid", fvalid, 0);
        check("arst_data", fdata, 0);
        valid = 4'b0110;
        #1; check("arst_ready", ready, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1; check("post_rst_grant", ready, 4'b0010);
        step();
        check("post_rst_data", fdata, {2'd1, 1'b0, 16'hA001});
        valid = '0;
        step();
        step();
        check("sb_drained", sb.size(), 0);

        // three-source instance
        for (int k = 0; k < 8; k++) begin
            valid3 = (k < 6) ? 3'b111 : 3'b000;
            #1;
            check("n3_grant", ready3, (k < 6) ? (32'd1 << (k % 3)) : 32'd0);
            check("n3_ptr_range", dut3.r_rr_ptr < 2'd3, 1);
            if (fvalid3) begin
                if (sb3.size() == 0) check("n3_underflow", 1, 0);
                else check("n3_data", fdata3, sb3.pop_front());
            end
            if (k < 6) sb3.push_back({2'(k % 3), data3[(k % 3)*PW +: PW]});
            step();
        end
        check("n3_drained", sb3.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
